// File: rtl/icache_refill.sv
// icache_refill: fetches a missed 32-bit instruction word from a 16-bit
// instruction memory in two half-word beats, returns it with a one-cycle
// fetch strobe and keeps a saturating count of completed refills.
module icache_refill #(
    parameter int ADDR_W = 20,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              resetn,
    input  logic              read_en,
    input  logic              cache_miss,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              fetch,
    output logic [31:0]       write_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic              busy,
    output logic [CNT_W-1:0]  miss_count
);

    typedef enum logic [2:0] {IDLE, LO, HI, DONE, HOLD} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] base;
    logic              abort;
    logic              start;
    logic              unused_addr_lsb;

    // Word alignment discards the byte offset inside the word.
    assign unused_addr_lsb = ^miss_addr[1:0];
    assign start           = (state == IDLE) && cache_miss && read_en;

    // State register.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state and Moore outputs; fetch additionally qualifies on read_en.
    always_comb begin
        state_nx = state;
        mem_req  = 1'b0;
        mem_addr = '0;
        busy     = 1'b1;
        fetch    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (cache_miss && read_en) state_nx = LO;
            end
            LO: begin
                mem_req  = 1'b1;
                mem_addr = base;
                // A request once raised is held to its ack, even when aborting.
                if (mem_ack) state_nx = (abort || !read_en) ? IDLE : HI;
            end
            HI: begin
                mem_req  = 1'b1;
                mem_addr = {base[ADDR_W-1:2], 2'b10};
                if (mem_ack) state_nx = (abort || !read_en) ? IDLE : DONE;
            end
            DONE: begin
                fetch    = read_en;
                state_nx = HOLD;
            end
            HOLD:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Latch the aligned base on miss acceptance; remember any read_en drop.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            base  <= '0;
            abort <= 1'b0;
        end else if (start) begin
            base  <= {miss_addr[ADDR_W-1:2], 2'b00};
            abort <= 1'b0;
        end else if ((state == LO || state == HI) && !read_en) begin
            abort <= 1'b1;
        end
    end

    // Capture each accepted beat into its half of the returned word.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            write_data <= '0;
        end else if (mem_ack) begin
            if (state == LO) write_data[15:0]  <= mem_rdata;
            if (state == HI) write_data[31:16] <= mem_rdata;
        end
    end

    // Count delivered refills, sticking at all-ones.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn)
            miss_count <= '0;
        else if (state == DONE && read_en && miss_count != {CNT_W{1'b1}})
            miss_count <= miss_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: a wait-state memory model plus a second
// instance with a 2-bit counter for the saturation sequence.
module tb_icache_refill;

    localparam int ADDR_W = 20;

    logic              CLK = 1'b0;
    logic              resetn;
    logic              read_en, cache_miss;
    logic [ADDR_W-1:0] miss_addr;
    logic              fetch, mem_req, busy, mem_ack;
    logic [31:0]       write_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_rdata;
    logic [15:0]       miss_count;

    logic              s_fetch, s_req, s_busy;
    logic [31:0]       s_wdata;
    logic [ADDR_W-1:0] s_addr;
    logic [1:0]        s_count;

    int n_cmp = 0;
    int n_err = 0;
    int waits = 0;
    int wcnt;

    always #5 CLK = ~CLK;

    icache_refill #(.ADDR_W(ADDR_W), .CNT_W(16)) u_dut (
        .CLK(CLK), .resetn(resetn), .read_en(read_en), .cache_miss(cache_miss),
        .miss_addr(miss_addr), .fetch(fetch), .write_data(write_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .busy(busy), .miss_count(miss_count)
    );

    // Same stimulus and memory responses, so it runs in lockstep with u_dut.
    icache_refill #(.ADDR_W(ADDR_W), .CNT_W(2)) u_sat (
        .CLK(CLK), .resetn(resetn), .read_en(read_en), .cache_miss(cache_miss),
        .miss_addr(miss_addr), .fetch(s_fetch), .write_data(s_wdata),
        .mem_req(s_req), .mem_addr(s_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .busy(s_busy), .miss_count(s_count)
    );

    // Memory: acks after 'waits' stalled request cycles, reset with resetn.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn)                wcnt <= 0;
        else if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else                        wcnt <= 0;
    end

    // Memory contents and ack decode.
    always_comb begin
        mem_ack = mem_req && (wcnt == waits);
        case (mem_addr)
            20'h00104: mem_rdata = 16'h1234;
            20'h00106: mem_rdata = 16'hABCD;
            20'h00200: mem_rdata = 16'h5555;
            20'h00202: mem_rdata = 16'hAAAA;
            default:   mem_rdata = 16'hDEAD;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        logic [6:0] e_busy, e_req, e_fetch;
        resetn = 1'b0; read_en = 1'b0; cache_miss = 1'b0; miss_addr = '0;

        // Reset state
        @(negedge CLK);
        chk("rst_busy", busy, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_fetch", fetch, 0);
        chk("rst_wdata", write_data, 0);
        chk("rst_count", miss_count, 0);
        resetn = 1'b1; read_en = 1'b1;
        step();

        // Basic refill, zero wait states
        waits = 0; miss_addr = 20'h00104; cache_miss = 1'b1;
        chk("t1_c0_busy", busy, 0);
        step(); cache_miss = 1'b0;
        chk("t1_c1_req", mem_req, 1);
        chk("t1_c1_addr", mem_addr, 32'h00104);
        step();
        chk("t1_c2_req", mem_req, 1);
        chk("t1_c2_addr", mem_addr, 32'h00106);
        chk("t1_c2_fetch", fetch, 0);
        step();
        chk("t1_c3_fetch", fetch, 1);
        chk("t1_c3_wdata", write_data, 32'hABCD1234);
        chk("t1_c3_req", mem_req, 0);
        step();
        chk("t1_c4_fetch", fetch, 0);
        chk("t1_c4_busy", busy, 1);
        chk("t1_c4_count", miss_count, 1);
        chk("t1_c4_sat", s_count, 1);
        step();
        chk("t1_c5_busy", busy, 0);

        // Wait states and alignment
        waits = 3; miss_addr = 20'h00203; cache_miss = 1'b1;
        step(); cache_miss = 1'b0; miss_addr = 20'h00FFF;
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("t2_c%0d_req", c), mem_req, 1);
            chk($sformatf("t2_c%0d_addr", c), mem_addr, (c <= 4) ? 32'h00200 : 32'h00202);
            chk($sformatf("t2_c%0d_ack", c), mem_ack, (c == 4 || c == 8) ? 1 : 0);
            chk($sformatf("t2_c%0d_fetch", c), fetch, 0);
            step();
        end
        chk("t2_c9_fetch", fetch, 1);
        chk("t2_c9_wdata", write_data, 32'hAAAA5555);
        step();
        chk("t2_c10_count", miss_count, 2);
        chk("t2_c10_sat", s_count, 2);
        step();
        chk("t2_c11_busy", busy, 0);

        // Abort during LO wait states
        waits = 3; miss_addr = 20'h00300; cache_miss = 1'b1;
        step(); cache_miss = 1'b0;
        chk("t3_c1_req", mem_req, 1);
        read_en = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            step();
            chk($sformatf("t3_c%0d_req", c), mem_req, 1);
            chk($sformatf("t3_c%0d_addr", c), mem_addr, 32'h00300);
            chk($sformatf("t3_c%0d_ack", c), mem_ack, (c == 4) ? 1 : 0);
            chk($sformatf("t3_c%0d_fetch", c), fetch, 0);
        end
        step();
        chk("t3_c5_busy", busy, 0);
        chk("t3_c5_req", mem_req, 0);
        chk("t3_c5_count", miss_count, 2);
        read_en = 1'b1;
        step();
        chk("t3_c6_busy", busy, 0);
        chk("t3_c6_fetch", fetch, 0);

        // Back-to-back misses with cache_miss held high
        waits = 0; miss_addr = 20'h00104; cache_miss = 1'b1;
        e_busy = 7'b1011110; e_req = 7'b1000110; e_fetch = 7'b0001000;
        for (int c = 0; c <= 6; c++) begin
            chk($sformatf("t4_c%0d_busy", c), busy, e_busy[c]);
            chk($sformatf("t4_c%0d_req", c), mem_req, e_req[c]);
            chk($sformatf("t4_c%0d_fetch", c), fetch, e_fetch[c]);
            if (c == 4) begin
                chk("t4_c4_count", miss_count, 3);
                chk("t4_c4_sat", s_count, 3);
            end
            if (c < 6) step();
        end
        cache_miss = 1'b0;
        chk("t4_c6_addr", mem_addr, 32'h00104);
        repeat (4) step();
        chk("t4_c10_busy", busy, 0);
        chk("t4_c10_count", miss_count, 4);
        chk("t4_c10_sat", s_count, 3);

        // Asynchronous reset in HI
        waits = 2; miss_addr = 20'h00104; cache_miss = 1'b1;
        step(); cache_miss = 1'b0;
        step(); step();
        chk("t5_c3_ack", mem_ack, 1);
        step();
        chk("t5_c4_addr", mem_addr, 32'h00106);
        #2 resetn = 1'b0;
        #1;
        chk("t5_rst_req", mem_req, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_fetch", fetch, 0);
        chk("t5_rst_addr", mem_addr, 0);
        chk("t5_rst_wdata", write_data, 0);
        chk("t5_rst_count", miss_count, 0);
        chk("t5_rst_sat", s_count, 0);
        @(negedge CLK);
        resetn = 1'b1;
        waits = 0; cache_miss = 1'b1;
        chk("t5_r0_busy", busy, 0);
        step(); cache_miss = 1'b0;
        chk("t5_r1_req", mem_req, 1);
        chk("t5_r1_addr", mem_addr, 32'h00104);
        step(); step();
        chk("t5_r3_fetch", fetch, 1);
        chk("t5_r3_wdata", write_data, 32'hABCD1234);
        step();
        chk("t5_r4_count", miss_count, 1);
        step();
        chk("t5_r5_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
